// File: rtl/uart_word_loader_if.sv
// rtl/uart_word_loader_if.sv - pixel memory write port bundle for uart_word_loader
//
// Purpose : groups the memory write bus driven by the UART word loader.
// Ports   :
//    mem_wdata  DATA_W  packed little-endian word to memory
//    mem_addr   ADDR_W  write address
//    mem_we     1       one-cycle write strobe
// Modports: master (loader side, drives the bus), slave (memory side).

interface uart_word_loader_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;

   modport master (output mem_wdata, output mem_addr, output mem_we);
   modport slave  (input  mem_wdata, input  mem_addr, input  mem_we);
endinterface

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - UART receiver packing bytes into words written to pixel memory
//
// Purpose : deserialises 8N1 bytes (8E1 when UART_PARITY_EN is defined) from
//           the host, packs them little-endian into DATA_W-bit words and
//           writes them to consecutive addresses until IMG_WORDS words have
//           been stored, then raises done.
// Macro   : UART_PARITY_EN - adds an even-parity bit after the data bits.
// Ports   :
//    clk        in   system clock, rising edge
//    rst_n      in   synchronous active-low reset
//    enable     in   loader enable; low returns to IDLE, clears address and done
//    rx         in   asynchronous UART serial input, idle high
//    mem        if   memory write port (mem_wdata, mem_addr, mem_we)
//    done       out  sticky, IMG_WORDS words written
//    frame_err  out  sticky, bad stop bit (or parity); cleared only by reset
//    rx_LED     out  high while a byte is being received

module uart_word_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 16,
   parameter int IMG_WORDS    = 65536
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               rx,
   uart_word_loader_if.master mem,
   output logic               done,
   output logic               frame_err,
   output logic               rx_LED
);

   localparam int BYTES  = DATA_W / 8;
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH,
      S_WRITE
`ifdef UART_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t state, state_nx;

   logic              rx_meta, rxs;
   logic [CNT_W-1:0]  baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic [DATA_W-1:0] word_buf;
   logic [BIDX_W-1:0] byte_idx;

   // Strobes decoded by the FSM for the datapath.
   logic sample;
   logic accept;
   logic stop_bad;

`ifdef UART_PARITY_EN
   logic par_bad;
`endif

   // ------------------------------------------------------------------
   // rx synchroniser; preset high so reset never looks like a start bit.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and decoded strobes
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      sample   = 1'b0;
      accept   = 1'b0;
      stop_bad = 1'b0;
      rx_LED   = 1'b0;

      case (state)
         S_IDLE: begin
            if (enable && !done && !rxs) begin
               state_nx = S_START;
            end
         end

         // Half-bit check filters glitches shorter than half a bit.
         S_START: begin
            rx_LED = 1'b1;
            if (baud_cnt == HALF_LAST) begin
               sample   = 1'b1;
               state_nx = rxs ? S_IDLE : S_DATA;
            end
         end

         S_DATA: begin
            rx_LED = 1'b1;
            if (baud_cnt == FULL_LAST) begin
               sample = 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_nx = S_PARITY;
`else
                  state_nx = S_STOP;
`endif
               end
            end
         end

`ifdef UART_PARITY_EN
         S_PARITY: begin
            rx_LED = 1'b1;
            if (baud_cnt == FULL_LAST) begin
               sample   = 1'b1;
               state_nx = S_STOP;
            end
         end
`endif

         S_STOP: begin
            rx_LED = 1'b1;
            if (baud_cnt == FULL_LAST) begin
               sample = 1'b1;
               if (!rxs) begin
                  stop_bad = 1'b1;
                  state_nx = S_WAIT_HIGH;
`ifdef UART_PARITY_EN
               end else if (par_bad) begin
                  state_nx = S_IDLE;
`endif
               end else begin
                  accept   = 1'b1;
                  state_nx = (byte_idx == LAST_BYTE) ? S_WRITE : S_IDLE;
               end
            end
         end

         // A low stop bit means we lost framing; wait for the line to idle.
         S_WAIT_HIGH: begin
            if (rxs) begin
               state_nx = S_IDLE;
            end
         end

         S_WRITE: begin
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase

      if (!enable) begin
         state_nx = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // Baud counter: restarts on every state change and every sample, so
   // the data, parity and stop samples all land one bit period apart.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baud_cnt <= '0;
      end else if ((state_nx != state) || sample || !rx_LED) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Datapath: shift register, word assembly and memory write port.
   // mem_we is registered off the WRITE state, so the strobe appears two
   // clocks after the stop-bit sample and the address advances after it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt       <= '0;
         shreg         <= '0;
         word_buf      <= '0;
         byte_idx      <= '0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         done          <= 1'b0;
         frame_err     <= 1'b0;
`ifdef UART_PARITY_EN
         par_bad       <= 1'b0;
`endif
      end else if (!enable) begin
         // frame_err deliberately survives a disable.
         bit_cnt      <= '0;
         word_buf     <= '0;
         byte_idx     <= '0;
         mem.mem_we   <= 1'b0;
         mem.mem_addr <= '0;
         done         <= 1'b0;
      end else begin
         mem.mem_we <= (state == S_WRITE);

         if (state == S_WRITE) begin
            mem.mem_wdata <= word_buf;
         end

         // Address holds at the last word so it never wraps.
         if (mem.mem_we) begin
            if (mem.mem_addr == LAST_ADDR) begin
               done <= 1'b1;
            end else begin
               mem.mem_addr <= mem.mem_addr + 1'b1;
            end
         end

         if (state == S_START) begin
            bit_cnt <= '0;
         end

         // LSB first: shifting in at the top leaves bit 0 at shreg[0].
         if (sample && (state == S_DATA)) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (stop_bad) begin
            frame_err <= 1'b1;
         end

`ifdef UART_PARITY_EN
         if (state == S_START) begin
            par_bad <= 1'b0;
         end
         // Even parity: the parity bit equals the XOR of the data bits.
         if (sample && (state == S_PARITY) && (rxs != ^shreg)) begin
            par_bad   <= 1'b1;
            frame_err <= 1'b1;
         end
`endif

         if (accept) begin
            for (int i = 0; i < BYTES; i++) begin
               if (byte_idx == BIDX_W'(i)) begin
                  word_buf[i*8 +: 8] <= shreg;
               end
            end
            byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - self-checking bench for uart_word_loader

module tb_uart_word_loader;

   localparam int CPB = 4;
   localparam int DW  = 16;
   localparam int AW  = 2;
   localparam int IW  = 4;
   localparam int NB  = DW / 8;

   logic clk = 1'b0;
   logic rst_n, enable, rx;
   logic done, frame_err, rx_LED;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor state (written only by the monitor process).
   logic [AW+DW-1:0] obs_q[$];
   int   led_cycles = 0;
   int   we_long    = 0;
   logic prev_we    = 1'b0;

   // Reference model state (written only by the stimulus process).
   logic [7:0]       m_part[$];
   logic [AW+DW-1:0] exp_q[$];
   int               m_addr;
   bit               m_done;
   bit               m_ferr;

   uart_word_loader_if #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

   uart_word_loader #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .IMG_WORDS   (IW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .rx       (rx),
      .mem      (mem_if.master),
      .done     (done),
      .frame_err(frame_err),
      .rx_LED   (rx_LED)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_if.mem_we) obs_q.push_back({mem_if.mem_addr, mem_if.mem_wdata});
      if (mem_if.mem_we && prev_we) we_long <= we_long + 1;
      prev_we <= mem_if.mem_we;
      if (rx_LED) led_cycles <= led_cycles + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop_bit,
                            input bit use_par, input logic par_bit);
      rx = 1'b0; idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i]; idle(CPB);
      end
      if (use_par) begin
         rx = par_bit; idle(CPB);
      end
      rx = stop_bit; idle(CPB);
      rx = 1'b1; idle(CPB);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b1; rx = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic model_reset();
      m_part.delete();
      exp_q.delete();
      m_addr = 0;
      m_done = 0;
      m_ferr = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good);
      logic [DW-1:0] w;
      if (m_done) return;
      if (!good) begin
         m_ferr = 1;
         return;
      end
      m_part.push_back(b);
      if (m_part.size() == NB) begin
         w = '0;
         for (int i = 0; i < NB; i++) w = w | (DW'(m_part[i]) << (8 * i));
         exp_q.push_back({AW'(m_addr), w});
         m_part.delete();
         if (m_addr == IW - 1) m_done = 1;
         else m_addr = m_addr + 1;
      end
   endtask

   task automatic test_reset();
      int base;
      rst_n = 1'b0; enable = 1'b1; rx = 1'b1;
      idle(3);
      n_tests++; if (mem_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_if.mem_we); end
      n_tests++; if (mem_if.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_if.mem_addr); end
      n_tests++; if (mem_if.mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_if.mem_wdata); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
      n_tests++; if (rx_LED !== 1'b0) begin n_fail++; $display("FAIL reset_led got %b want 0", rx_LED); end
      rst_n = 1'b1; idle(2);
      // Reset in the middle of the completing byte must abort without a write.
      base = obs_q.size();
      uart_send(8'h34, 1'b1, 0, 1'b0);
      rx = 1'b0; idle(CPB * 3);
      rst_n = 1'b0; idle(2);
      rx = 1'b1; idle(1);
      rst_n = 1'b1; idle(20);
      n_tests++; if (obs_q.size() - base !== 0) begin n_fail++; $display("FAIL reset_abort_writes got %0d want 0", obs_q.size() - base); end
      n_tests++; if (rx_LED !== 1'b0) begin n_fail++; $display("FAIL reset_abort_led got %b want 0", rx_LED); end
   endtask

   task automatic test_single_word();
      int base;
      do_reset();
      base = obs_q.size();
      uart_send(8'h34, 1'b1, 0, 1'b0);
      uart_send(8'h12, 1'b1, 0, 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() - base !== 1) begin
         n_fail++; $display("FAIL single_count got %0d want 1", obs_q.size() - base);
      end else begin
         n_tests++;
         if (obs_q[base] !== {AW'(0), 16'h1234}) begin n_fail++; $display("FAIL single_write got %h want %h", obs_q[base], {AW'(0), 16'h1234}); end
      end
      n_tests++; if (mem_if.mem_addr !== AW'(1)) begin n_fail++; $display("FAIL single_addr_after got %0d want 1", mem_if.mem_addr); end
      n_tests++; if (mem_if.mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL single_wdata_hold got %h want 1234", mem_if.mem_wdata); end
      n_tests++; if (we_long !== 0) begin n_fail++; $display("FAIL single_we_width got %0d long strobes want 0", we_long); end
   endtask

   task automatic test_full_image();
      int base;
      do_reset();
      base = obs_q.size();
      for (int i = 0; i < 8; i++) uart_send(8'(i), 1'b1, 0, 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() - base !== 4) begin
         n_fail++; $display("FAIL full_count got %0d want 4", obs_q.size() - base);
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs_q[base+k] !== {AW'(k), 8'(2*k+1), 8'(2*k)}) begin
               n_fail++; $display("FAIL full_write%0d got %h want %h", k, obs_q[base+k], {AW'(k), 8'(2*k+1), 8'(2*k)});
            end
         end
      end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done got %b want 1", done); end
      n_tests++; if (mem_if.mem_addr !== AW'(3)) begin n_fail++; $display("FAIL full_addr got %0d want 3", mem_if.mem_addr); end
      uart_send(8'hFF, 1'b1, 0, 1'b0);
      uart_send(8'hFF, 1'b1, 0, 1'b0);
      idle(8);
      n_tests++; if (obs_q.size() - base !== 4) begin n_fail++; $display("FAIL after_done_count got %0d want 4", obs_q.size() - base); end
      n_tests++; if (mem_if.mem_addr !== AW'(3)) begin n_fail++; $display("FAIL after_done_addr got %0d want 3", mem_if.mem_addr); end
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL after_done_sticky got %b want 1", done); end
      enable = 1'b0; idle(2);
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL disable_done got %b want 0", done); end
      n_tests++; if (mem_if.mem_addr !== '0) begin n_fail++; $display("FAIL disable_addr got %0d want 0", mem_if.mem_addr); end
      enable = 1'b1; idle(2);
   endtask

   task automatic test_glitch();
      int base, l0;
      do_reset();
      base = obs_q.size();
      l0 = led_cycles;
      rx = 1'b0; idle(1);
      rx = 1'b1; idle(10);
      n_tests++; if (led_cycles - l0 !== CPB / 2) begin n_fail++; $display("FAIL glitch_led_cycles got %0d want %0d", led_cycles - l0, CPB / 2); end
      n_tests++; if (rx_LED !== 1'b0) begin n_fail++; $display("FAIL glitch_led_idle got %b want 0", rx_LED); end
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr got %b want 0", frame_err); end
      uart_send(8'h34, 1'b1, 0, 1'b0);
      uart_send(8'h12, 1'b1, 0, 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() - base !== 1) begin
         n_fail++; $display("FAIL glitch_count got %0d want 1", obs_q.size() - base);
      end else begin
         n_tests++;
         if (obs_q[base] !== {AW'(0), 16'h1234}) begin n_fail++; $display("FAIL glitch_write got %h want %h", obs_q[base], {AW'(0), 16'h1234}); end
      end
   endtask

   task automatic test_frame_err();
      int base;
      do_reset();
      base = obs_q.size();
      uart_send(8'hA5, 1'b0, 0, 1'b0);
      idle(4);
      n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", frame_err); end
      uart_send(8'h11, 1'b1, 0, 1'b0);
      uart_send(8'h22, 1'b1, 0, 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() - base !== 1) begin
         n_fail++; $display("FAIL ferr_count got %0d want 1", obs_q.size() - base);
      end else begin
         n_tests++;
         if (obs_q[base] !== {AW'(0), 16'h2211}) begin n_fail++; $display("FAIL ferr_write got %h want %h", obs_q[base], {AW'(0), 16'h2211}); end
      end
      n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky got %b want 1", frame_err); end
   endtask

   task automatic test_enable();
      int base;
      do_reset();
      base = obs_q.size();
      uart_send(8'h55, 1'b1, 0, 1'b0);
      enable = 1'b0; idle(3);
      // A full frame while disabled must be ignored.
      uart_send(8'h99, 1'b1, 0, 1'b0);
      enable = 1'b1; idle(2);
      uart_send(8'h66, 1'b1, 0, 1'b0);
      uart_send(8'h77, 1'b1, 0, 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() - base !== 1) begin
         n_fail++; $display("FAIL enable_count got %0d want 1", obs_q.size() - base);
      end else begin
         n_tests++;
         if (obs_q[base] !== {AW'(0), 16'h7766}) begin n_fail++; $display("FAIL enable_write got %h want %h", obs_q[base], {AW'(0), 16'h7766}); end
      end
      n_tests++; if (mem_if.mem_addr !== AW'(1)) begin n_fail++; $display("FAIL enable_addr got %0d want 1", mem_if.mem_addr); end
   endtask

   task automatic test_random();
      int base, n;
      logic [7:0] b;
      bit good;
      do_reset();
      model_reset();
      base = obs_q.size();
      for (int f = 0; f < 24; f++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 5) != 0);
         uart_send(b, good, 0, 1'b0);
         model_byte(b, good);
         idle($urandom_range(0, 6));
      end
      idle(10);
      n = obs_q.size() - base;
      n_tests++; if (n !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", n, exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         n_tests++;
         if (obs_q[base+k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_write%0d got %h want %h", k, obs_q[base+k], exp_q[k]); end
      end
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done got %b want %b", done, m_done); end
      n_tests++; if (frame_err !== m_ferr) begin n_fail++; $display("FAIL rand_ferr got %b want %b", frame_err, m_ferr); end
      n_tests++; if (mem_if.mem_addr !== AW'(m_addr)) begin n_fail++; $display("FAIL rand_addr got %0d want %0d", mem_if.mem_addr, m_addr); end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity();
      int base;
      do_reset();
      base = obs_q.size();
      uart_send(8'h03, 1'b1, 1, 1'b0);
      uart_send(8'h04, 1'b1, 1, 1'b1);
      idle(8);
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL par_good_ferr got %b want 0", frame_err); end
      uart_send(8'h03, 1'b1, 1, 1'b1);
      idle(4);
      n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_ferr got %b want 1", frame_err); end
      uart_send(8'h05, 1'b1, 1, 1'b0);
      uart_send(8'h06, 1'b1, 1, 1'b0);
      idle(8);
      n_tests++;
      if (obs_q.size() - base !== 2) begin
         n_fail++; $display("FAIL par_count got %0d want 2", obs_q.size() - base);
      end else begin
         n_tests++;
         if (obs_q[base] !== {AW'(0), 16'h0403}) begin n_fail++; $display("FAIL par_write0 got %h want %h", obs_q[base], {AW'(0), 16'h0403}); end
         n_tests++;
         if (obs_q[base+1] !== {AW'(1), 16'h0605}) begin n_fail++; $display("FAIL par_write1 got %h want %h", obs_q[base+1], {AW'(1), 16'h0605}); end
      end
   endtask
`endif

   initial begin
      rst_n  = 1'b0;
      enable = 1'b1;
      rx     = 1'b1;
      test_reset();
      test_single_word();
      test_full_image();
      test_glitch();
      test_frame_err();
      test_enable();
      test_random();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
